// File: rtl/delay_pkg.sv
// delay_pkg: shared widths, scheduler state encoding and saturating add
// for the delay datapath. DATA_W, ADDR_W and FB_W set the widths of the
// whole block, so delay_sched and delay_mix take their widths from here.
package delay_pkg;

    localparam int unsigned DATA_W = 16;  // signed sample width
    localparam int unsigned ADDR_W = 16;  // SRAM word address; depth 2**ADDR_W
    localparam int unsigned FB_W   = 8;   // feedback gain fraction bits

    typedef enum logic [2:0] {
        IDLE,
        ADC,
        RD,
        WR,
        DAC
    } sched_state_t;

    // Signed a+b clamped to the DATA_W two's complement range.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/delay_mix.sv
// delay_mix: combinational mix of the new sample x and the delayed sample d.
//   x, d  in  : new and delayed samples (signed)
//   fb    in  : unsigned feedback gain, gain = fb / 2**FB_W
//   y_c   out : DAC sample, (x + d) >>> 1
//   w_c   out : sample written back to the buffer
// Build option: FEEDBACK_EN adds d*gain into the written-back sample;
// without it w_c = x and fb is ignored.
module delay_mix
    import delay_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] d,
    input  logic [FB_W-1:0]   fb,
    output logic [DATA_W-1:0] y_c,
    output logic [DATA_W-1:0] w_c
);

    // Halved sum of two DATA_W values always fits back in DATA_W.
    logic [DATA_W:0] sum;
    assign sum = {x[DATA_W-1], x} + {d[DATA_W-1], d};
    assign y_c = DATA_W'(sum >> 1);

`ifdef FEEDBACK_EN
    localparam int unsigned PROD_W = DATA_W + FB_W + 1;

    // fb is zero-extended so the product stays signed; |d*fb| >> FB_W < |d|.
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] term;
    assign prod = PROD_W'($signed(d)) * PROD_W'($signed({1'b0, fb}));
    assign term = DATA_W'(prod >>> FB_W);
    assign w_c  = sat_add(x, term);
`else
    logic unused_fb;
    assign unused_fb = ^fb;
    assign w_c       = x;
`endif

endmodule

// File: rtl/delay_sched.sv
// delay_sched: per-sample sequencer for the delay line.
// Each accepted step runs ADC conversion -> SRAM read of the delayed sample
// -> SRAM write of the new sample -> DAC output, and owns the write pointer.
//   clk, rst          : clock, synchronous active-high reset
//   step              : one-cycle sample tick (ignored while busy -> overrun)
//   delay_len, fb     : delay in samples and feedback gain, latched on step
//   adc_*             : conversion request / completion / data
//   ram_*             : level request held until ram_done, we/addr/wdata stable
//   dac_*             : one-cycle start with data / completion
//   busy, overrun     : not IDLE / sticky step-while-busy flag
// Build option: FEEDBACK_EN (inside delay_mix) enables feedback into the buffer.
module delay_sched
    import delay_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [FB_W-1:0]   fb,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_done,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dac_start,
    output logic [DATA_W-1:0] dac_data,
    input  logic              dac_done,
    output logic              busy,
    output logic              overrun
);

    sched_state_t      state_q, state_d;
    logic              adc_start_q, adc_start_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              dac_start_q, dac_start_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] delay_len_q, delay_len_d;
    logic [FB_W-1:0]   fb_q, fb_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] y_c, w_c;

    delay_mix u_mix (
        .x   (x_q),
        .d   (d_q),
        .fb  (fb_q),
        .y_c (y_c),
        .w_c (w_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; SRAM completions only count while a request is up.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (step)                  state_d = ADC;
            ADC:     if (adc_done)              state_d = RD;
            RD:      if (ram_req_q && ram_done) state_d = WR;
            WR:      if (ram_req_q && ram_done) state_d = DAC;
            DAC:     if (dac_done)              state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        adc_start_d = 1'b0;
        dac_start_d = 1'b0;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        dac_data_d  = dac_data_q;
        wr_ptr_d    = wr_ptr_q;
        delay_len_d = delay_len_q;
        fb_d        = fb_q;
        x_d         = x_q;
        d_d         = d_q;
        busy_d      = (state_d != IDLE);
        overrun_d   = overrun_q | (step & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (step) begin
                    delay_len_d = delay_len;
                    fb_d        = fb;
                    adc_start_d = 1'b1;
                end
            end
            ADC: begin
                // Read address wraps modulo the buffer depth; delay 0 reads
                // the oldest sample (full-buffer delay).
                if (adc_done) begin
                    x_d        = adc_data;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = wr_ptr_q - delay_len_q;
                end
            end
            RD: begin
                if (ram_req_q && ram_done) begin
                    d_d       = ram_rdata;
                    ram_req_d = 1'b0;
                end
            end
            WR: begin
                // First WR cycle keeps ram_req low, giving the idle gap.
                if (ram_req_q && ram_done) begin
                    ram_req_d   = 1'b0;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    dac_start_d = 1'b1;
                    dac_data_d  = y_c;
                end else if (!ram_req_q) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_ptr_q;
                    ram_wdata_d = w_c;
                end
            end
            DAC: begin
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_start_q <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            dac_start_q <= 1'b0;
            dac_data_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            delay_len_q <= '0;
            fb_q        <= '0;
            x_q         <= '0;
            d_q         <= '0;
        end else begin
            adc_start_q <= adc_start_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            dac_start_q <= dac_start_d;
            dac_data_q  <= dac_data_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            delay_len_q <= delay_len_d;
            fb_q        <= fb_d;
            x_q         <= x_d;
            d_q         <= d_d;
        end
    end

    assign adc_start = adc_start_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign dac_start = dac_start_q;
    assign dac_data  = dac_data_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: scoreboard bench for delay_sched. Expected read/write/DAC
// transactions are queued when a step is issued and checked by the engine
// responder as the DUT produces them.
`timescale 1ns/1ps
module tb_delay_sched;
    import delay_pkg::*;

    logic              clk = 1'b0;
    logic              rst, step;
    logic [ADDR_W-1:0] delay_len;
    logic [FB_W-1:0]   fb;
    logic              adc_start, adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              ram_req, ram_we, ram_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              dac_start, dac_done;
    logic [DATA_W-1:0] dac_data;
    logic              busy, overrun;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] adc_val;
    logic [15:0] exp_wr_ptr;
    logic [15:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    logic [15:0] exp_dac_q[$];
    logic [15:0] mem[int];      // SRAM contents seen by the engine
    logic [15:0] ref_mem[int];  // expected buffer contents

    delay_sched dut (
        .clk(clk), .rst(rst), .step(step), .delay_len(delay_len), .fb(fb),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_done(ram_done), .ram_rdata(ram_rdata),
        .dac_start(dac_start), .dac_data(dac_data), .dac_done(dac_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return 16'(s >>> 1);
    endfunction

    function automatic logic [15:0] model_w(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] g);
`ifdef FEEDBACK_EN
        int p, s;
        p = int'($signed(b)) * int'(g);
        p = p >>> 8;
        s = int'($signed(a)) + p;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
`else
        logic [7:0] unused_g;
        unused_g = g;
        if (b == 16'h0 && unused_g == 8'h0) return a;
        return a;
`endif
    endfunction

    // Engines: each done follows its request by one cycle; SRAM checks vs queue.
    initial begin
        logic        prev_done;
        logic [31:0] e;
        logic [15:0] e16;
        adc_done = 1'b0; ram_done = 1'b0; dac_done = 1'b0;
        adc_data = '0;   ram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            prev_done = ram_done;
            adc_done = 1'b0; ram_done = 1'b0; dac_done = 1'b0;
            if (adc_start === 1'b1) begin
                adc_done = 1'b1;
                adc_data = adc_val;
            end
            if (ram_req === 1'b1 && !prev_done) begin
                ram_done = 1'b1;
                if (ram_we) begin
                    if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", 32'(ram_addr), 32'(e[31:16]));
                        chk("wr_data", 32'(ram_wdata), 32'(e[15:0]));
                    end
                    mem[int'(ram_addr)] = ram_wdata;
                end else begin
                    if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                    else begin
                        e16 = exp_rd_q.pop_front();
                        chk("rd_addr", 32'(ram_addr), 32'(e16));
                    end
                    ram_rdata = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 16'h0;
                end
            end
            if (dac_start === 1'b1) begin
                dac_done = 1'b1;
                if (exp_dac_q.size() == 0) chk("dac_unexpected", 32'd1, 32'd0);
                else begin
                    e16 = exp_dac_q.pop_front();
                    chk("dac_data", 32'(dac_data), 32'(e16));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin cyc(); n++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Queue the expected transactions of one sample and issue its step.
    task automatic start_sample(input logic [15:0] dl, input logic [15:0] xv,
                                input logic [15:0] rv, input bit preset,
                                input logic [7:0] fbv);
        logic [15:0] ra, dv, wv;
        ra = exp_wr_ptr - dl;
        if (preset) begin
            mem[int'(ra)] = rv;
            ref_mem[int'(ra)] = rv;
        end
        dv = ref_mem.exists(int'(ra)) ? ref_mem[int'(ra)] : 16'h0;
        wv = model_w(xv, dv, fbv);
        exp_rd_q.push_back(ra);
        exp_wr_q.push_back({exp_wr_ptr, wv});
        exp_dac_q.push_back(model_y(xv, dv));
        ref_mem[int'(exp_wr_ptr)] = wv;
        exp_wr_ptr = exp_wr_ptr + 16'd1;
        delay_len = dl; fb = fbv; adc_val = xv;
        step = 1'b1; cyc(); step = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic run_sample(input logic [15:0] dl, input logic [15:0] xv,
                              input logic [15:0] rv, input bit preset,
                              input logic [7:0] fbv);
        start_sample(dl, xv, rv, preset, fbv);
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
        exp_wr_ptr = 16'h0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] ra, wv;
        rst = 1'b1; step = 1'b0; delay_len = '0; fb = '0; adc_val = '0;
        exp_wr_ptr = 16'h0;
        repeat (3) cyc();
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_ram_req",   32'(ram_req),   32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_dac_start", 32'(dac_start), 32'd0);
        chk("rst_dac_data",  32'(dac_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        rst = 1'b0;

        // Basic sample: read FFFF, write 0 <- 0100, DAC 0200.
        run_sample(16'd1, 16'h0100, 16'h0300, 1'b1, 8'h80);
        // wr_ptr advanced to 1: read addr 0 returns the 0100 just written.
        run_sample(16'd1, 16'h0010, 16'h0000, 1'b0, 8'h80);

        // Step during RD is ignored and sets sticky overrun.
        start_sample(16'd1, 16'h0040, 16'h0000, 1'b0, 8'h80);
        n = 0;
        while (!(ram_req && !ram_we) && n < 20) begin cyc(); n++; end
        chk("rd_seen", 32'(ram_req & ~ram_we), 32'd1);
        step = 1'b1; cyc(); step = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_idle();
        repeat (3) cyc();
        chk("no_extra_sample", 32'(busy), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        run_sample(16'd3, 16'hFF00, 16'h0000, 1'b0, 8'h80);
        chk("overrun_hold", 32'(overrun), 32'd1);
        do_reset();
        chk("overrun_rst_clr", 32'(overrun), 32'd0);

        // Reset during the write aborts the sample; wr_ptr stays 0.
        ra = exp_wr_ptr - 16'd1;
        mem[int'(ra)] = 16'h0500; ref_mem[int'(ra)] = 16'h0500;
        wv = model_w(16'h0200, 16'h0500, 8'h80);
        exp_rd_q.push_back(ra);
        exp_wr_q.push_back({exp_wr_ptr, wv});
        delay_len = 16'd1; fb = 8'h80; adc_val = 16'h0200;
        step = 1'b1; cyc(); step = 1'b0;
        n = 0;
        while (!(ram_req && ram_we) && n < 20) begin cyc(); n++; end
        chk("wr_seen", 32'(ram_req & ram_we), 32'd1);
        rst = 1'b1; cyc();
        chk("abort_ram_req", 32'(ram_req), 32'd0);
        chk("abort_busy",    32'(busy),    32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        exp_wr_q.delete();
        exp_dac_q.delete();

        // Step coinciding with the final dac_done is still ignored.
        start_sample(16'd1, 16'h0300, 16'h0100, 1'b1, 8'h80);
        n = 0;
        while (!dac_start && n < 20) begin cyc(); n++; end
        chk("dac_seen", 32'(dac_start), 32'd1);
        step = 1'b1; cyc(); step = 1'b0;
        chk("dacdone_step_busy",    32'(busy),    32'd0);
        chk("dacdone_step_overrun", 32'(overrun), 32'd1);
        cyc();
        chk("dacdone_step_noadc", 32'(adc_start), 32'd0);

        // Pointer wrap: FFFF then 0.
        force dut.wr_ptr_q = 16'hFFFF;
        repeat (2) cyc();
        release dut.wr_ptr_q;
        exp_wr_ptr = 16'hFFFF;
        run_sample(16'd1, 16'h0111, 16'h0222, 1'b1, 8'h40);
        run_sample(16'd1, 16'h0333, 16'h0000, 1'b0, 8'h40);

        // Saturation corners.
        run_sample(16'd1, 16'h7FFF, 16'h7FFF, 1'b1, 8'hFF);
        run_sample(16'd1, 16'h8000, 16'h8000, 1'b1, 8'hFF);
        run_sample(16'd2, 16'h8001, 16'h7FFF, 1'b1, 8'h01);

        // delay_len=0 at wr_ptr=5: read 5 (old contents) then write 5.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_sample(16'd1, 16'(i * 16'h0101), 16'h0000, 1'b0, 8'h80);
        run_sample(16'd0, 16'h0800, 16'h1234, 1'b1, 8'h80);
        run_sample(16'd1, 16'h0002, 16'h0000, 1'b0, 8'h80);

        chk("sb_rd_empty",  32'(exp_rd_q.size()),  32'd0);
        chk("sb_wr_empty",  32'(exp_wr_q.size()),  32'd0);
        chk("sb_dac_empty", 32'(exp_dac_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Per-sample sequencer for the delay datapath. On each `step` it:
  1. runs one ADC conversion;
  2. reads the delayed sample from SPI SRAM;
  3. writes the new sample into the circular buffer;
  4. sends the mixed sample to the DAC.
- Sits between the top-level sample tick and the three SPI engines (ADC, SRAM, DAC). It owns the circular-buffer pointers and is the only master of the SRAM engine.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- ADDR_W, 16, SRAM word-address width; buffer depth = 2**ADDR_W samples.
- FB_W, 8, feedback gain width (unsigned fraction, gain = fb/2**FB_W).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- step  in  1  one-cycle sample tick
- delay_len  in  ADDR_W  delay in samples, latched at accepted step
- fb  in  FB_W  feedback gain, latched at accepted step (used only with FEEDBACK_EN)
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle, adc_data valid
- adc_data  in  DATA_W  converted sample
- ram_req  out  1  level request, held until ram_done
- ram_we  out  1  1=write, 0=read; stable while ram_req
- ram_addr  out  ADDR_W  word address; stable while ram_req
- ram_wdata  out  DATA_W  write data; stable while ram_req
- ram_done  in  1  one-cycle completion; ram_rdata valid on read
- ram_rdata  in  DATA_W  read data
- dac_start  out  1  one-cycle request, dac_data valid
- dac_data  out  DATA_W  output sample
- dac_done  in  1  one-cycle DAC completion
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: step arrived while busy

Behaviour:
- Reset: every output is 0; wr_ptr=0; state=IDLE. Reset mid-operation aborts the current sample immediately, so ram_req drops on the next edge. Downstream engines must tolerate an abandoned request.
- States:
  - IDLE -> ADC on step. This cycle latches delay_len and fb, and pulses adc_start for 1 cycle.
  - ADC: wait adc_done; register the sample as x. Compute rd_addr = wr_ptr - delay_len, modulo 2**ADDR_W. Next state RD.
  - RD: ram_req=1, ram_we=0, ram_addr=rd_addr. On ram_done, register ram_rdata as d and drop ram_req. Next state WR.
  - WR: ram_req=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=w. On ram_done: wr_ptr <= wr_ptr+1 (wraps 2**ADDR_W-1 -> 0), drop ram_req. Next state DAC.
  - DAC: on entry pulse dac_start for 1 cycle with dac_data=y. Wait dac_done, then go to IDLE.
- ram_req is deasserted for at least 1 cycle between RD and WR.
- A step arriving while busy is ignored and sets overrun=1. overrun is cleared only by rst.
- step and the final dac_done in the same cycle: the step is still ignored and sets overrun.
- Mix arithmetic:
  - y = sat((x + d) >>> 1), using a DATA_W+1-bit intermediate. The arithmetic shift cannot overflow; truncate to DATA_W.
  - w = x (without FEEDBACK_EN).
- delay_len=0: rd_addr equals wr_ptr, so the read returns the oldest sample (full-buffer delay of 2**ADDR_W). This is legal and intended.
- Minimum latency: step to dac_start = 4 cycles plus the engine wait times, when each done arrives 1 cycle after its request.
- dac_data holds its value until the next DAC state.

Optional Feature:
- FEEDBACK_EN
  - Defined: w = sat(x + ((d * fb) >>> FB_W)). The product is signed (DATA_W+FB_W+1 bits). Saturate to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - Undefined: w = x and the fb port is ignored. The port stays in the interface for pin compatibility.

Decomposition:
- Package delay_pkg:
  - state enum sched_state_t {IDLE, ADC, RD, WR, DAC};
  - DATA_W/ADDR_W defaults;
  - function sat_add for saturating signed addition.
- One sub-module, delay_mix: combinational mix of x, d and fb into y and w. It holds the FEEDBACK_EN ifdef so the FSM stays free of arithmetic.

Test Plan:
- Reset then step, with adc_data=16'h0100 and ram_rdata=16'h0300, every done 1 cycle after its request:
  - required sequence is adc_start, read addr 16'hFFFF (delay_len=1, wr_ptr=0), write addr 0 with wdata 16'h0100;
  - dac_data=16'h0200; wr_ptr=1; busy back to 0.
- Step again during RD -> ignored; overrun=1 and stays 1 after the sample completes; only rst clears it.
- Preload wr_ptr=16'hFFFF via 65535 samples (or force), step -> write addr 16'hFFFF, then the next write addr is 0.
- Saturation: adc_data=16'h7FFF, ram_rdata=16'h7FFF -> dac_data=16'h7FFF. With FEEDBACK_EN and fb=8'hFF -> ram_wdata=16'h7FFF. With adc_data=16'h8000, ram_rdata=16'h8000 -> ram_wdata=16'h8000.
- Assert rst while ram_req=1 in WR -> next cycle ram_req=0, busy=0, wr_ptr unchanged, overrun=0.
- delay_len=0, wr_ptr=5 -> read addr=5 and write addr=5; the read precedes the write, so it returns the old contents.
